// File: rtl/pipe_stall_ctrl.sv
// Central stall/bubble controller for the 5-stage pipeline: merges MEM wait,
// multi-cycle divide, load-use and ID stall requests into the per-stage hold bus.
module pipe_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_busy,
  input  logic        ex_is_div,
  input  logic        ex_is_load,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_stallreq,
  output logic [5:0]  stall,
  output logic        div_done,
  output logic        div_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q;
  logic             load_use;
  logic             div_src;
  logic [5:0]       stall_raw;

  assign load_use = ex_is_load & ex_rf_we & (ex_rf_waddr != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_rf_waddr)) |
                     (id_uses_rt & (id_rt == ex_rf_waddr)));

  // The IDLE detect cycle already counts as the first stalled divide cycle.
  assign div_src = (state_q == DIV_RUN) | ((state_q == IDLE) & ex_is_div);

  always_comb begin
    stall_raw = 6'b000000;
    if (mem_busy)                    stall_raw = 6'b011111;
    else if (div_src)                stall_raw = 6'b001111;
    else if (load_use | id_stallreq) stall_raw = 6'b000111;
  end

  assign stall     = rst ? 6'b000000 : stall_raw;
  assign div_busy  = ~rst & div_src;
  assign div_done  = ~rst & (state_q == DIV_DONE) & ~mem_busy;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ex_is_div) begin
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (!mem_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall != 6'b000000) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule
